control_fsm_hs: RTL and testbench

CONTROL_FSM_HS -- requirements
Module: control_fsm_hs

---
 rtl/control_fsm_hs.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_control_fsm_hs.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_fsm_hs.sv
// control_fsm_hs
//    Multi-cycle instruction sequencer with a memory handshake. Walks each
//    instruction through fetch, decode, execute, memory and writeback states.
//    Every memory wait is guarded by a timeout counter, and an illegal opcode
//    can raise a trap. Both traps can be disabled for legacy behaviour.
//
//    Parameters
//       MEM_TIMEOUT  consecutive mem_ready-low wait cycles before a timeout trap (1-255)
//       TRAP_ENABLE  1: illegal/timeout traps active; 0: no traps, waits are unbounded
//
//    Ports
//       clk, reset       single clock; synchronous active-high reset
//       opcode, funct3   instruction fields used for decode and branch selection
//       zero_flag        ALU zero result (beq/bne)
//       alu_result       ALU result; bit 0 carries the compare outcome (blt/bge/...)
//       mem_byte_en      store byte lanes, forwarded to mem_write in MEMWRITE
//       mem_ready        memory access completes this cycle
//       mem_req, adr_src, ir_write, reg_write, pc_update, pc_src, mem_write,
//       alu_src_a, alu_src_b, result_src   datapath controls
//       trap, trap_cause trap indication, valid only in the TRAP state
//       fsm_state        current state code
//
//    state     | meaning
//    ----------+-----------------------------------------------
//    FETCH     | read instruction at PC, PC += 4 on mem_ready
//    DECODE    | compute branch/jump target, dispatch on opcode
//    EXEC_R    | register-register ALU op
//    JAL       | link value = old PC + 4, PC <- jump target
//    EXEC_I    | register-immediate ALU op
//    MEMADR    | effective address = rs1 + imm
//    ALUWB     | write ALU output to register file
//    MEMWRITE  | store, byte strobes held until mem_ready
//    MEMREAD   | load, wait for mem_ready
//    MEMWB     | write load data to register file
//    BRANCH    | compare and conditionally take branch
//    LUI       | 0 + imm
//    AUIPC     | old PC + imm
//    JALR_CALC | rs1 + imm target
//    JALR_LINK | PC <- target, link value = old PC + 4
//    TRAP      | PC <- trap vector, report cause

module control_fsm_hs #(
   parameter int MEM_TIMEOUT = 16,
   parameter bit TRAP_ENABLE = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic        zero_flag,
   input  logic [31:0] alu_result,
   input  logic [3:0]  mem_byte_en,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        adr_src,
   output logic        ir_write,
   output logic        reg_write,
   output logic        pc_update,
   output logic [1:0]  pc_src,
   output logic [3:0]  mem_write,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic        result_src,
   output logic        trap,
   output logic [1:0]  trap_cause,
   output logic [4:0]  fsm_state
);

   typedef enum logic [4:0] {
      ST_FETCH     = 5'd0,
      ST_DECODE    = 5'd1,
      ST_EXEC_R    = 5'd2,
      ST_JAL       = 5'd3,
      ST_EXEC_I    = 5'd4,
      ST_MEMADR    = 5'd5,
      ST_ALUWB     = 5'd6,
      ST_MEMWRITE  = 5'd7,
      ST_MEMREAD   = 5'd8,
      ST_MEMWB     = 5'd9,
      ST_BRANCH    = 5'd10,
      ST_LUI       = 5'd11,
      ST_AUIPC     = 5'd12,
      ST_JALR_CALC = 5'd13,
      ST_JALR_LINK = 5'd14,
      ST_TRAP      = 5'd15
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic [1:0]  cause_q, cause_d;

   logic        in_wait;
   logic        timeout_hit;
   logic        illegal;
   logic        branch_taken;

   // Only the compare bit of alu_result is used by the sequencer.
   logic        unused_alu_hi;
   assign unused_alu_hi = ^alu_result[31:1];

   assign fsm_state = state_q;

   always_comb begin
      state_d      = state_q;
      cause_d      = cause_q;
      wait_cnt_d   = wait_cnt_q;
      mem_req      = 1'b0;
      adr_src      = 1'b0;
      ir_write     = 1'b0;
      reg_write    = 1'b0;
      pc_update    = 1'b0;
      pc_src       = 2'd0;
      mem_write    = 4'd0;
      alu_src_a    = 2'd0;
      alu_src_b    = 2'd0;
      result_src   = 1'b0;
      trap         = 1'b0;
      trap_cause   = CAUSE_NONE;
      illegal      = 1'b0;
      branch_taken = 1'b0;

      in_wait     = (state_q == ST_FETCH) || (state_q == ST_MEMREAD) ||
                    (state_q == ST_MEMWRITE);
      // mem_ready is checked before timeout_hit in every wait state, which
      // gives a completing access priority over a coinciding timeout.
      timeout_hit = TRAP_ENABLE && !mem_ready && (wait_cnt_q == WAIT_LAST);

      unique case (state_q)
         ST_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write  = 1'b1;
               pc_update = 1'b1;
               state_d   = ST_DECODE;
            end else if (timeout_hit) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_TIMEOUT;
            end
         end

         ST_DECODE: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd1;
            unique case (opcode)
               OP_R:      state_d = ST_EXEC_R;
               OP_I:      state_d = ST_EXEC_I;
               OP_LOAD,
               OP_STORE:  state_d = ST_MEMADR;
               OP_BRANCH: begin
                  // funct3 010/011 are not assigned to any branch.
                  if (funct3[2:1] == 2'b01) illegal = 1'b1;
                  else                      state_d = ST_BRANCH;
               end
               OP_JAL:    state_d = ST_JAL;
               OP_JALR:   state_d = ST_JALR_CALC;
               OP_LUI:    state_d = ST_LUI;
               OP_AUIPC:  state_d = ST_AUIPC;
               OP_FENCE:  state_d = ST_FETCH;
               default:   illegal = 1'b1;
            endcase
            // Legacy mode simply holds in DECODE on an illegal instruction.
            if (illegal && TRAP_ENABLE) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_ILLEGAL;
            end
         end

         ST_EXEC_R: begin
            state_d = ST_ALUWB;
         end

         ST_EXEC_I: begin
            alu_src_b = 2'd1;
            state_d   = ST_ALUWB;
         end

         ST_LUI: begin
            alu_src_a = 2'd2;
            alu_src_b = 2'd1;
            state_d   = ST_ALUWB;
         end

         ST_AUIPC: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd1;
            state_d   = ST_ALUWB;
         end

         ST_JAL: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd2;
            pc_update = 1'b1;
            pc_src    = 2'd1;
            state_d   = ST_ALUWB;
         end

         ST_JALR_CALC: begin
            alu_src_b = 2'd1;
            state_d   = ST_JALR_LINK;
         end

         ST_JALR_LINK: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd2;
            pc_src    = 2'd2;
            pc_update = 1'b1;
            state_d   = ST_ALUWB;
         end

         ST_ALUWB: begin
            reg_write = 1'b1;
            state_d   = ST_FETCH;
         end

         ST_BRANCH: begin
            unique case (funct3)
               3'b000:  branch_taken = zero_flag;
               3'b001:  branch_taken = !zero_flag;
               3'b100,
               3'b101,
               3'b110,
               3'b111:  branch_taken = alu_result[0];
               default: branch_taken = 1'b0;
            endcase
            if (branch_taken) begin
               pc_src    = 2'd1;
               pc_update = 1'b1;
            end
            state_d = ST_FETCH;
         end

         ST_MEMADR: begin
            alu_src_b = 2'd1;
            state_d   = (opcode == OP_STORE) ? ST_MEMWRITE : ST_MEMREAD;
         end

         ST_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) begin
               state_d = ST_MEMWB;
            end else if (timeout_hit) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_TIMEOUT;
            end
         end

         ST_MEMWB: begin
            reg_write  = 1'b1;
            result_src = 1'b1;
            state_d    = ST_FETCH;
         end

         ST_MEMWRITE: begin
            mem_req   = 1'b1;
            adr_src   = 1'b1;
            mem_write = mem_byte_en;
            if (mem_ready) begin
               state_d = ST_FETCH;
            end else if (timeout_hit) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_TIMEOUT;
            end
         end

         ST_TRAP: begin
            trap       = 1'b1;
            trap_cause = cause_q;
            pc_src     = 2'd3;
            pc_update  = 1'b1;
            cause_d    = CAUSE_NONE;
            state_d    = ST_FETCH;
         end

         default: begin
            state_d = ST_FETCH;
         end
      endcase

      // Any state change (including entry into a wait state) restarts the
      // count; it saturates so legacy mode can wait indefinitely.
      if (state_d != state_q) begin
         wait_cnt_d = 8'd0;
      end else if (in_wait && !mem_ready && (wait_cnt_q != 8'hFF)) begin
         wait_cnt_d = wait_cnt_q + 8'd1;
      end

      // Side-effecting strobes stay quiet while reset is held.
      if (reset) begin
         mem_req    = 1'b0;
         ir_write   = 1'b0;
         pc_update  = 1'b0;
         reg_write  = 1'b0;
         mem_write  = 4'd0;
         trap       = 1'b0;
         trap_cause = CAUSE_NONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_FETCH;
         wait_cnt_q <= 8'd0;
         cause_q    <= CAUSE_NONE;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         cause_q    <= cause_d;
      end
   end

endmodule

// File: tb/tb_control_fsm_hs.sv
module tb_control_fsm_hs;

   localparam int MT = 16;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   logic        clk;
   logic        reset;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        zero_flag;
   logic [31:0] alu_result;
   logic [3:0]  mem_byte_en;
   logic        mem_ready;

   logic        mem_req, adr_src, ir_write, reg_write, pc_update, result_src, trap;
   logic [1:0]  pc_src, alu_src_a, alu_src_b, trap_cause;
   logic [3:0]  mem_write;
   logic [4:0]  fsm_state;

   logic        l_mem_req, l_adr_src, l_ir_write, l_reg_write, l_pc_update, l_result_src, l_trap;
   logic [1:0]  l_pc_src, l_alu_src_a, l_alu_src_b, l_trap_cause;
   logic [3:0]  l_mem_write;
   logic [4:0]  l_fsm_state;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [4:0] st;
      logic       rdy;
      logic [1:0] cause;
   } step_t;

   step_t plan[$];

   control_fsm_hs #(.MEM_TIMEOUT(MT), .TRAP_ENABLE(1'b1)) u_dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
      .zero_flag(zero_flag), .alu_result(alu_result), .mem_byte_en(mem_byte_en),
      .mem_ready(mem_ready), .mem_req(mem_req), .adr_src(adr_src),
      .ir_write(ir_write), .reg_write(reg_write), .pc_update(pc_update),
      .pc_src(pc_src), .mem_write(mem_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .result_src(result_src), .trap(trap),
      .trap_cause(trap_cause), .fsm_state(fsm_state)
   );

   control_fsm_hs #(.MEM_TIMEOUT(4), .TRAP_ENABLE(1'b0)) u_leg (
      .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
      .zero_flag(zero_flag), .alu_result(alu_result), .mem_byte_en(mem_byte_en),
      .mem_ready(mem_ready), .mem_req(l_mem_req), .adr_src(l_adr_src),
      .ir_write(l_ir_write), .reg_write(l_reg_write), .pc_update(l_pc_update),
      .pc_src(l_pc_src), .mem_write(l_mem_write), .alu_src_a(l_alu_src_a),
      .alu_src_b(l_alu_src_b), .result_src(l_result_src), .trap(l_trap),
      .trap_cause(l_trap_cause), .fsm_state(l_fsm_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [18:0] obs_vec;
   assign obs_vec = {mem_req, adr_src, ir_write, reg_write, pc_update, pc_src, mem_write,
                     alu_src_a, alu_src_b, result_src, trap, trap_cause};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected control vector for one cycle, straight from the per-state rules.
   function automatic logic [18:0] exp_out(input logic [4:0] st, input logic rdy,
                                           input logic [2:0] f3, input logic zf,
                                           input logic a0, input logic [3:0] be,
                                           input logic [1:0] cs);
      logic       mreq, asrc, irw, rw, pcu, rsrc, tr;
      logic [1:0] pcs, sa, sb, tc;
      logic [3:0] mw;
      mreq = 0; asrc = 0; irw = 0; rw = 0; pcu = 0; rsrc = 0; tr = 0;
      pcs = 0; sa = 0; sb = 0; tc = 0; mw = 0;
      case (st)
         5'd0:  begin mreq = 1; irw = rdy; pcu = rdy; end
         5'd1:  begin sa = 1; sb = 1; end
         5'd2:  ;
         5'd3:  begin sa = 1; sb = 2; pcu = 1; pcs = 1; end
         5'd4:  sb = 1;
         5'd5:  sb = 1;
         5'd6:  rw = 1;
         5'd7:  begin mreq = 1; asrc = 1; mw = be; end
         5'd8:  begin mreq = 1; asrc = 1; end
         5'd9:  begin rw = 1; rsrc = 1; end
         5'd10: if ((f3 == 3'd0 && zf) || (f3 == 3'd1 && !zf) || (f3[2] && a0)) begin
                   pcu = 1; pcs = 1;
                end
         5'd11: begin sa = 2; sb = 1; end
         5'd12: begin sa = 1; sb = 1; end
         5'd13: sb = 1;
         5'd14: begin sa = 1; sb = 2; pcs = 2; pcu = 1; end
         5'd15: begin tr = 1; tc = cs; pcs = 3; pcu = 1; end
         default: ;
      endcase
      return {mreq, asrc, irw, rw, pcu, pcs, mw, sa, sb, rsrc, tr, tc};
   endfunction

   task automatic push(input logic [4:0] st, input logic [1:0] cs);
      step_t s;
      s.st = st; s.rdy = 1'($urandom); s.cause = cs;
      plan.push_back(s);
   endtask

   // n cycles of mem_ready low followed by a completing cycle, or a timeout trap.
   task automatic push_wait(input logic [4:0] st, input int n, output bit trapped);
      step_t s;
      trapped = 0;
      s.st = st; s.rdy = 1'b0; s.cause = 2'd0;
      if (n >= MT) begin
         for (int i = 0; i < MT; i++) plan.push_back(s);
         push(5'd15, 2'd2);
         trapped = 1;
      end else begin
         for (int i = 0; i < n; i++) plan.push_back(s);
         s.rdy = 1'b1;
         plan.push_back(s);
      end
   endtask

   task automatic build_plan(input logic [6:0] op, input logic [2:0] f3, input int k, input int m);
      bit tr;
      plan.delete();
      push_wait(5'd0, k, tr);
      if (tr) return;
      push(5'd1, 2'd0);
      case (op)
         OP_R:      begin push(5'd2, 0);  push(5'd6, 0); end
         OP_I:      begin push(5'd4, 0);  push(5'd6, 0); end
         OP_LUI:    begin push(5'd11, 0); push(5'd6, 0); end
         OP_AUIPC:  begin push(5'd12, 0); push(5'd6, 0); end
         OP_JAL:    begin push(5'd3, 0);  push(5'd6, 0); end
         OP_JALR:   begin push(5'd13, 0); push(5'd14, 0); push(5'd6, 0); end
         OP_LOAD:   begin
                       push(5'd5, 0);
                       push_wait(5'd8, m, tr);
                       if (!tr) push(5'd9, 0);
                    end
         OP_STORE:  begin push(5'd5, 0); push_wait(5'd7, m, tr); end
         OP_BRANCH: if (f3 == 3'b010 || f3 == 3'b011) push(5'd15, 1); else push(5'd10, 0);
         OP_FENCE:  ;
         default:   push(5'd15, 2'd1);
      endcase
   endtask

   // Runs one instruction from FETCH; stop >= 0 truncates the run after that many cycles.
   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [3:0] be,
                            input logic zf, input logic [31:0] alu, input int k, input int m,
                            input int stop);
      int n;
      opcode = op; funct3 = f3; mem_byte_en = be; zero_flag = zf; alu_result = alu;
      build_plan(op, f3, k, m);
      n = (stop >= 0 && stop < plan.size()) ? stop : plan.size();
      for (int i = 0; i < n; i++) begin
         mem_ready = plan[i].rdy;
         @(negedge clk);
         chk($sformatf("state[op=%b step %0d]", op, i), {27'd0, fsm_state}, {27'd0, plan[i].st});
         chk($sformatf("outs[op=%b st=%0d]", op, plan[i].st), {13'd0, obs_vec},
             {13'd0, exp_out(plan[i].st, plan[i].rdy, f3, zf, alu[0], be, plan[i].cause)});
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
   endtask

   function automatic logic [6:0] pick_op(input int idx);
      logic [6:0] r;
      case (idx)
         0: return OP_R;     1: return OP_I;      2: return OP_LOAD;
         3: return OP_STORE; 4: return OP_BRANCH; 5: return OP_JAL;
         6: return OP_JALR;  7: return OP_LUI;    8: return OP_AUIPC;
         9: return OP_FENCE;
         default: begin
            do r = 7'($urandom);
            while (r == OP_R || r == OP_I || r == OP_LOAD || r == OP_STORE || r == OP_BRANCH ||
                   r == OP_JAL || r == OP_JALR || r == OP_LUI || r == OP_AUIPC || r == OP_FENCE);
            return r;
         end
      endcase
   endfunction

   initial begin
      reset = 1'b1; opcode = OP_R; funct3 = 0; zero_flag = 0; alu_result = 0;
      mem_byte_en = 0; mem_ready = 1'b1;

      // Reset holds strobes low even though mem_ready=1 in FETCH.
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_state", {27'd0, fsm_state}, 32'd0);
      chk("rst_strobes", {24'd0, mem_req, ir_write, pc_update, reg_write, mem_write != 0, trap, trap_cause},
          32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // add, no wait states: 0,1,2,6 then FETCH.
      run_instr(OP_R, 3'd0, 4'h0, 1'b0, 32'd0, 0, 0, -1);
      // store with 3 wait cycles on the data access.
      run_instr(OP_STORE, 3'd2, 4'b0011, 1'b0, 32'd0, 0, 3, -1);
      // bne taken, blt not taken.
      run_instr(OP_BRANCH, 3'b001, 4'h0, 1'b0, 32'd0, 0, 0, -1);
      run_instr(OP_BRANCH, 3'b100, 4'h0, 1'b0, 32'd0, 0, 0, -1);
      // Boundary: ready arrives on the last allowed wait cycle (no trap).
      run_instr(OP_LOAD, 3'd2, 4'h0, 1'b0, 32'd0, MT - 1, MT - 1, -1);
      // Fetch timeout after MT low cycles.
      run_instr(OP_R, 3'd0, 4'h0, 1'b0, 32'd0, MT, 0, -1);
      // Store timeout.
      run_instr(OP_STORE, 3'd0, 4'hF, 1'b0, 32'd0, 0, MT, -1);

      // Illegal opcode: trap with cause 1; legacy instance holds DECODE.
      do_reset();
      run_instr(7'b1111111, 3'd0, 4'h0, 1'b0, 32'd0, 0, 0, -1);
      @(negedge clk);
      chk("leg_illegal_state", {27'd0, l_fsm_state}, 32'd1);
      chk("leg_illegal_trap", {31'd0, l_trap}, 32'd0);
      @(posedge clk); #1;

      // Legacy instance never times out.
      do_reset();
      mem_ready = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      @(negedge clk);
      chk("leg_wait_state", {27'd0, l_fsm_state}, 32'd0);
      chk("leg_wait_req", {31'd0, l_mem_req}, 32'd1);
      chk("leg_wait_trap", {31'd0, l_trap}, 32'd0);
      @(posedge clk); #1;

      // Reset in the middle of a MEMREAD wait.
      do_reset();
      run_instr(OP_LOAD, 3'd2, 4'h0, 1'b0, 32'd0, 0, 8, 5);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_memread_req", {31'd0, mem_req}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_memread_state", {27'd0, fsm_state}, 32'd0);
      chk("rst_memread_req2", {31'd0, mem_req}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Randomized instruction stream.
      for (int t = 0; t < 80; t++) begin
         int k, m;
         k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(MT - 2, MT + 1)) : int'($urandom_range(0, 3));
         m = ($urandom_range(0, 9) == 0) ? int'($urandom_range(MT - 2, MT + 1)) : int'($urandom_range(0, 3));
         run_instr(pick_op(int'($urandom_range(0, 11))), 3'($urandom), 4'($urandom),
                   1'($urandom), $urandom, k, m, -1);
      end
      @(negedge clk);
      chk("final_state", {27'd0, fsm_state}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
